// File: rtl/stream_demux_1to4_if.sv
// Handshake bundle for the 1-to-4 stream demultiplexer: one tagged input stream, four output channels.
// Optional DEMUX_STATS_EN adds the per-channel frame counters and their clear input.
interface stream_demux_1to4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_last;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_last;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic               sel_err;
`ifdef DEMUX_STATS_EN
  logic [4*8-1:0]     frame_cnt;
  logic               stats_clr;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready, stats_clr,
    input  in_ready, out_data, out_last, out_valid, sel_err, frame_cnt
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready, stats_clr,
    output in_ready, out_data, out_last, out_valid, sel_err, frame_cnt
  );
`else
  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid, sel_err
  );
`endif
endinterface

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demux with per-channel single-entry holding registers and frame locking.
// Define DEMUX_STATS_EN to add saturating per-channel frame counters (frame_cnt, stats_clr).
module stream_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  stream_demux_1to4_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       lock_q;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [3:0]       last_q;
  logic [WIDTH-1:0] data_q [4];
  logic             sel_err_q;

  logic [1:0]       dest;
  logic             in_ready_c;
  logic             accept;
  logic [3:0]       load;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dest       = (state_q == LOCKED) ? lock_q : bus.in_sel;
    in_ready_c = ~valid_q[dest] | bus.out_ready[dest];
    accept     = bus.in_valid & in_ready_c;
    load       = 4'b0000;
    if (accept) begin
      load[dest] = 1'b1;
    end
    valid_d    = load | (valid_q & ~bus.out_ready);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_q    <= 2'd0;
      valid_q   <= 4'b0000;
      last_q    <= 4'b0000;
      sel_err_q <= 1'b0;
      // NOTE: the holding registers are only four words and their payload is visible at the ports, so they are reset like control state.
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      sel_err_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.in_data;
          last_q[k] <= bus.in_last;
        end
      end
      case (state_q)
        IDLE: begin
          if (accept && !bus.in_last) begin
            state_q <= LOCKED;
            lock_q  <= bus.in_sel;
          end
        end
        LOCKED: begin
          if (accept) begin
            sel_err_q <= (bus.in_sel != lock_q);
            if (bus.in_last) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.sel_err   = sel_err_q;

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [4];

  // Clear wins over a same-cycle frame completion; counters stick at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 8'd0;
      end
    end else if (bus.stats_clr) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k] && bus.in_last && (cnt_q[k] != 8'hFF)) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.frame_cnt[k*8 +: 8] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Scoreboard bench for stream_demux_1to4: directed scenarios plus randomized frames and consumer stalls.
// Builds with or without DEMUX_STATS_EN; the counter checks are only compiled in when it is defined.
module tb_stream_demux_1to4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  stream_demux_1to4_if #(.WIDTH(W)) bus ();

  stream_demux_1to4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel expected beat queues plus frame tracking.
  beat_t      exp_q [4][$];
  logic       in_frame;
  logic [1:0] frame_dest;
  logic       err_pending;
  bit         rand_rdy;
  int         cnt_model [4];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] data, input logic [1:0] sel, input logic last, output int waits);
    logic [1:0] dst;
    logic       err;
    bus.in_data  = data;
    bus.in_sel   = sel;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 500) begin
        n_checks++;
        $display("FAIL send timeout: data %0h sel %0d never accepted", data, sel);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    // A frame goes wherever its first beat pointed; later select values only raise an error.
    if (!in_frame) frame_dest = sel;
    dst      = frame_dest;
    err      = in_frame && (sel != frame_dest);
    in_frame = !last;
    exp_q[dst].push_back({data, last});
    if (last && cnt_model[dst] < 255) cnt_model[dst]++;
    @(posedge clk);
    err_pending = err;
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'($urandom);
    bus.in_last  = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      cnt_model[k] = 0;
    end
    in_frame    = 1'b0;
    frame_dest  = 2'd0;
    err_pending = 1'b0;
  endtask

  // Monitor: pops on each consumed beat, checks sel_err and stalled-register stability.
  initial begin
    beat_t      e;
    logic       hold_v [4];
    logic [W:0] hold_d [4];
    for (int k = 0; k < 4; k++) hold_v[k] = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int k = 0; k < 4; k++) hold_v[k] = 1'b0;
      end else begin
        check("sel_err", 64'(bus.sel_err), 64'(err_pending));
        err_pending = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (hold_v[k])
            check($sformatf("ch%0d stall hold", k),
                  64'({bus.out_data[k*W +: W], bus.out_last[k]}), 64'(hold_d[k]));
          if (bus.out_valid[k] && bus.out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              n_checks++;
              $display("FAIL ch%0d unexpected beat: got %0h expected none", k, bus.out_data[k*W +: W]);
            end else begin
              e = exp_q[k].pop_front();
              check($sformatf("ch%0d data", k), 64'(bus.out_data[k*W +: W]), 64'(e.data));
              check($sformatf("ch%0d last", k), 64'(bus.out_last[k]), 64'(e.last));
            end
          end
          hold_v[k] = bus.out_valid[k] & ~bus.out_ready[k];
          hold_d[k] = {bus.out_data[k*W +: W], bus.out_last[k]};
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 4'($urandom);
    end
  end

  initial begin
    int w;
    int len;
    logic [1:0] s0;
    logic [1:0] s;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = 2'd0;
    bus.in_last  = 1'b0;
    bus.out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    rand_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset out_valid", 64'(bus.out_valid), 64'h0);
    check("reset in_ready", 64'(bus.in_ready), 64'h1);
    check("reset sel_err", 64'(bus.sel_err), 64'h0);
    check("reset out_data", 64'(bus.out_data), 64'h0);
    check("reset out_last", 64'(bus.out_last), 64'h0);
    @(posedge clk); #1;

    // Single-beat frames.
    bus.out_ready = 4'hF;
    send(8'hA5, 2'd2, 1'b1, w);
    check("single ch2 valid", 64'(bus.out_valid), 64'b0100);
    send(8'h3C, 2'd0, 1'b1, w);
    check("single ch0 valid", 64'(bus.out_valid), 64'b0001);

    // Frame lock with mid-frame select changes, then a fresh frame.
    send(8'h11, 2'd1, 1'b0, w);
    send(8'h22, 2'd3, 1'b0, w);
    check("lock ch1 valid", 64'(bus.out_valid), 64'b0010);
    send(8'h33, 2'd0, 1'b1, w);
    check("lock last ch1 valid", 64'(bus.out_valid), 64'b0010);
    send(8'h44, 2'd2, 1'b1, w);
    check("after frame idle route", 64'(bus.out_valid), 64'b0100);
    idle(2);

    // Backpressure isolation on channel 1.
    bus.out_ready = 4'b1101;
    send(8'h51, 2'd1, 1'b1, w);
    bus.in_data = 8'h52; bus.in_sel = 2'd1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    check("stall in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send(8'h61, 2'd3, 1'b0, w);
    check("bypass beat0 waits", 64'(w), 64'h0);
    send(8'h62, 2'd3, 1'b0, w);
    check("bypass beat1 waits", 64'(w), 64'h0);
    send(8'h63, 2'd3, 1'b1, w);
    check("bypass beat2 waits", 64'(w), 64'h0);
    check("ch1 still held", 64'({bus.out_valid[1], bus.out_data[15:8]}), 64'h151);
    bus.out_ready = 4'hF;
    send(8'h52, 2'd1, 1'b1, w);
    check("release ch1 waits", 64'(w), 64'h0);

    // Full throughput on channel 0.
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 2'd0, 1'b1, w);
      check($sformatf("thru beat%0d waits", i), 64'(w), 64'h0);
      check($sformatf("thru beat%0d valid", i), 64'(bus.out_valid[0]), 64'h1);
    end
    idle(2);

    // Reset in the middle of a frame to channel 2.
    send(8'h71, 2'd2, 1'b0, w);
    send(8'h72, 2'd2, 1'b0, w);
    bus.out_ready[2] = 1'b0;
    @(negedge clk);
    check("midframe ch2 full", 64'(bus.out_valid), 64'b0100);
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset out_valid", 64'(bus.out_valid), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.out_ready = 4'hF;
    send(8'h81, 2'd0, 1'b1, w);
    check("post reset route ch0", 64'(bus.out_valid), 64'b0001);

    // Randomized frames, random select noise, gaps and consumer stalls.
    rand_rdy = 1;
    for (int f = 0; f < 150; f++) begin
      len = $urandom_range(1, 4);
      s0  = 2'($urandom);
      for (int b = 0; b < len; b++) begin
        s = (b == 0 || ($urandom % 4) != 0) ? s0 : 2'($urandom);
        send(8'($urandom), s, 1'(b == len - 1), w);
        if (($urandom % 4) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    bus.out_ready = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("ch%0d drained", k), 64'(exp_q[k].size()), 64'h0);

`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 300; i++) send(8'($urandom), 2'd3, 1'b1, w);
    for (int k = 0; k < 4; k++)
      check($sformatf("frame_cnt%0d", k), 64'(bus.frame_cnt[k*8 +: 8]), 64'(cnt_model[k]));
    check("frame_cnt3 saturated", 64'(bus.frame_cnt[31:24]), 64'd255);
    bus.stats_clr = 1'b1;
    @(posedge clk); #1;
    bus.stats_clr = 1'b0;
    for (int k = 0; k < 4; k++) cnt_model[k] = 0;
    check("frame_cnt cleared", 64'(bus.frame_cnt), 64'h0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
